// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC block sequencer: FSM states,
// shift-mux stage selects, and the block-class helper.
package cavlc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TOKEN,
    LEVEL,
    ZERO,
    BLK_END,
    MB_END
  } seqState_t;

  typedef enum logic [1:0] {
    BLK_LUMA,
    BLK_CHROMA_DC,
    BLK_CHROMA_AC
  } blkClass_t;

  localparam logic [4:0] NC_CHROMA_DC = 5'h1E;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_CT   = 2'd1;
  localparam logic [1:0] SEL_LV   = 2'd2;
  localparam logic [1:0] SEL_ZD   = 2'd3;

  // Block order within a macroblock is luma, then chroma DC, then chroma AC.
  function automatic blkClass_t blockClass(input logic [4:0] blkIdx,
                                           input int numLuma,
                                           input int numChromaDc);
    if (int'(blkIdx) < numLuma)
      return BLK_LUMA;
    else if (int'(blkIdx) < numLuma + numChromaDc)
      return BLK_CHROMA_DC;
    else
      return BLK_CHROMA_AC;
  endfunction

endpackage

// File: rtl/cavlc_shift_mux.sv
// Routes the active stage's shift request onto the shared bitstream shifter.
module cavlc_shift_mux
  import cavlc_pkg::*;
(
  input  logic [1:0] StageSel,
  input  logic [4:0] CtNumShift,
  input  logic       CtShiftEn,
  input  logic [4:0] LvNumShift,
  input  logic       LvShiftEn,
  input  logic [4:0] ZdNumShift,
  input  logic       ZdShiftEn,
  output logic [4:0] NumShift,
  output logic       ShiftEn
);

  always_comb begin
    NumShift = 5'd0;
    ShiftEn  = 1'b0;
    case (StageSel)
      SEL_CT: begin
        NumShift = CtNumShift;
        ShiftEn  = CtShiftEn;
      end
      SEL_LV: begin
        NumShift = LvNumShift;
        ShiftEn  = LvShiftEn;
      end
      SEL_ZD: begin
        NumShift = ZdNumShift;
        ShiftEn  = ZdShiftEn;
      end
      default: begin
        NumShift = 5'd0;
        ShiftEn  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cavlc_block_sequencer.sv
// Macroblock controller stepping each residual block through coeff_token,
// level and zero/run decode. Define CAVLC_WATCHDOG_EN to add a per-stage watchdog.
module cavlc_block_sequencer
  import cavlc_pkg::*;
#(
`ifdef CAVLC_WATCHDOG_EN
  parameter int WDOG_CYCLES   = 64,
`endif
  parameter int NUM_LUMA      = 16,
  parameter int NUM_CHROMA_DC = 2,
  parameter int NUM_CHROMA_AC = 8
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Start,
  input  logic [4:0] nC_In,
  input  logic       CtDone,
  input  logic [4:0] CtTotalCoeff,
  input  logic [4:0] CtNumShift,
  input  logic       CtShiftEn,
  input  logic       LvDone,
  input  logic [4:0] LvNumShift,
  input  logic       LvShiftEn,
  input  logic       ZdDone,
  input  logic [4:0] ZdNumShift,
  input  logic       ZdShiftEn,
  output logic       CtEn,
  output logic       LvEn,
  output logic       ZdEn,
  output logic [4:0] nC,
  output logic [4:0] TotalCoeff,
  output logic [4:0] NumShift,
  output logic       ShiftEn,
  output logic [4:0] BlkIdx,
  output logic       BlkValid,
  output logic       MbDone,
  output logic       Busy,
  output logic       Error
);

  localparam logic [4:0] LAST_BLK = 5'(NUM_LUMA + NUM_CHROMA_DC + NUM_CHROMA_AC - 1);

  seqState_t  state, nextState;
  logic [1:0] stageSel;
  logic       stageActive;
  logic       stageDone;
  logic       timeout;

  assign stageActive = (state == TOKEN) || (state == LEVEL) || (state == ZERO);
  assign stageDone   = ((state == TOKEN) && CtDone) ||
                       ((state == LEVEL) && LvDone) ||
                       ((state == ZERO)  && ZdDone);

`ifdef CAVLC_WATCHDOG_EN
  logic [6:0] wdogCnt;

  // Timeout fires on the last allowed cycle unless that cycle also brings Done.
  assign timeout = stageActive && !stageDone && (wdogCnt == 7'(WDOG_CYCLES - 1));
  assign Error   = timeout;

  always_ff @(posedge Clk) begin
    if (!nReset)
      wdogCnt <= 7'd0;
    else if (state != nextState)
      wdogCnt <= 7'd0;
    else if (stageActive)
      wdogCnt <= wdogCnt + 7'd1;
  end
`else
  assign timeout = 1'b0;
  assign Error   = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state      <= IDLE;
      BlkIdx     <= 5'd0;
      TotalCoeff <= 5'd0;
    end else begin
      state <= nextState;
      if ((state == IDLE) && Start)
        BlkIdx <= 5'd0;
      if ((state == TOKEN) && CtDone)
        TotalCoeff <= CtTotalCoeff;
      if ((state == BLK_END) && (BlkIdx != LAST_BLK)) begin
        BlkIdx     <= BlkIdx + 5'd1;
        TotalCoeff <= 5'd0;
      end
    end
  end

  always_comb begin
    nextState = state;
    CtEn      = 1'b0;
    LvEn      = 1'b0;
    ZdEn      = 1'b0;
    BlkValid  = 1'b0;
    MbDone    = 1'b0;
    Busy      = (state != IDLE);
    stageSel  = SEL_NONE;
    case (state)
      IDLE: begin
        if (Start)
          nextState = TOKEN;
      end
      TOKEN: begin
        CtEn     = 1'b1;
        stageSel = SEL_CT;
        if (CtDone)
          nextState = (CtTotalCoeff == 5'd0) ? BLK_END : LEVEL;
      end
      LEVEL: begin
        LvEn     = 1'b1;
        stageSel = SEL_LV;
        if (LvDone)
          nextState = ZERO;
      end
      ZERO: begin
        ZdEn     = 1'b1;
        stageSel = SEL_ZD;
        if (ZdDone)
          nextState = BLK_END;
      end
      BLK_END: begin
        BlkValid  = 1'b1;
        nextState = (BlkIdx == LAST_BLK) ? MB_END : TOKEN;
      end
      MB_END: begin
        MbDone    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (timeout)
      nextState = IDLE;
  end

  always_comb begin
    nC = nC_In;
    if (blockClass(BlkIdx, NUM_LUMA, NUM_CHROMA_DC) == BLK_CHROMA_DC)
      nC = NC_CHROMA_DC;
  end

  cavlc_shift_mux uShiftMux (
    .StageSel   (stageSel),
    .CtNumShift (CtNumShift),
    .CtShiftEn  (CtShiftEn),
    .LvNumShift (LvNumShift),
    .LvShiftEn  (LvShiftEn),
    .ZdNumShift (ZdNumShift),
    .ZdShiftEn  (ZdShiftEn),
    .NumShift   (NumShift),
    .ShiftEn    (ShiftEn)
  );

endmodule

// File: tb/tb_cavlc_block_sequencer.sv
// Directed bench for cavlc_block_sequencer; watchdog scenario runs when
// CAVLC_WATCHDOG_EN is defined.
module tb_cavlc_block_sequencer;

  logic       Clk = 1'b0;
  logic       nReset, Start;
  logic [4:0] nC_In;
  logic       CtDone, CtShiftEn, LvDone, LvShiftEn, ZdDone, ZdShiftEn;
  logic [4:0] CtTotalCoeff, CtNumShift, LvNumShift, ZdNumShift;
  logic       CtEn, LvEn, ZdEn, ShiftEn, BlkValid, MbDone, Busy, Error;
  logic [4:0] nC, TotalCoeff, NumShift, BlkIdx;

  int nChecks = 0;
  int nFails  = 0;

  always #5 Clk = ~Clk;

  cavlc_block_sequencer dut (
    .Clk          (Clk),
    .nReset       (nReset),
    .Start        (Start),
    .nC_In        (nC_In),
    .CtDone       (CtDone),
    .CtTotalCoeff (CtTotalCoeff),
    .CtNumShift   (CtNumShift),
    .CtShiftEn    (CtShiftEn),
    .LvDone       (LvDone),
    .LvNumShift   (LvNumShift),
    .LvShiftEn    (LvShiftEn),
    .ZdDone       (ZdDone),
    .ZdNumShift   (ZdNumShift),
    .ZdShiftEn    (ZdShiftEn),
    .CtEn         (CtEn),
    .LvEn         (LvEn),
    .ZdEn         (ZdEn),
    .nC           (nC),
    .TotalCoeff   (TotalCoeff),
    .NumShift     (NumShift),
    .ShiftEn      (ShiftEn),
    .BlkIdx       (BlkIdx),
    .BlkValid     (BlkValid),
    .MbDone       (MbDone),
    .Busy         (Busy),
    .Error        (Error)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clearInputs();
    Start = 1'b0; nC_In = 5'd0;
    CtDone = 1'b0; CtTotalCoeff = 5'd0; CtNumShift = 5'd0; CtShiftEn = 1'b0;
    LvDone = 1'b0; LvNumShift = 5'd0; LvShiftEn = 1'b0;
    ZdDone = 1'b0; ZdNumShift = 5'd0; ZdShiftEn = 1'b0;
  endtask

  task automatic test_reset();
    clearInputs();
    nReset = 1'b0;
    tick();
    tick();
    nChecks++; if ({CtEn, LvEn, ZdEn} !== 3'b000) begin nFails++; $display("FAIL reset_en actual=%b required=000", {CtEn, LvEn, ZdEn}); end
    nChecks++; if (BlkIdx !== 5'd0) begin nFails++; $display("FAIL reset_blkidx actual=%0d required=0", BlkIdx); end
    nChecks++; if (TotalCoeff !== 5'd0) begin nFails++; $display("FAIL reset_totalcoeff actual=%0d required=0", TotalCoeff); end
    nChecks++; if ({BlkValid, MbDone, Busy, Error, ShiftEn} !== 5'b0) begin nFails++; $display("FAIL reset_flags actual=%b required=00000", {BlkValid, MbDone, Busy, Error, ShiftEn}); end
    nChecks++; if ({NumShift, nC} !== 10'd0) begin nFails++; $display("FAIL reset_numshift_nc actual=%0d/%0d required=0/0", NumShift, nC); end
    nReset = 1'b1;
    tick();
    nChecks++; if (Busy !== 1'b0) begin nFails++; $display("FAIL idle_busy actual=%b required=0", Busy); end
  endtask

  task automatic test_all_zero();
    int pulses = 0;
    int lvZdSeen = 0;
    nC_In = 5'd7;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int blk = 0; blk < 26; blk++) begin
      nChecks++; if (CtEn !== 1'b1 || BlkIdx !== 5'(blk)) begin nFails++; $display("FAIL zero_token blk=%0d actual CtEn=%b BlkIdx=%0d required CtEn=1 BlkIdx=%0d", blk, CtEn, BlkIdx, blk); end
      if (blk == 0 || blk == 16 || blk == 17 || blk == 18) begin
        nChecks++; if (nC !== ((blk == 16 || blk == 17) ? 5'h1E : 5'd7)) begin nFails++; $display("FAIL nc_blk%0d actual=%0h required=%0h", blk, nC, (blk == 16 || blk == 17) ? 5'h1E : 5'd7); end
      end
      if (LvEn || ZdEn) lvZdSeen++;
      CtDone = 1'b1;
      tick();
      CtDone = 1'b0;
      if (BlkValid === 1'b1 && CtEn === 1'b0) pulses++;
      if (LvEn || ZdEn) lvZdSeen++;
      if (blk < 25) tick();
    end
    nChecks++; if (pulses !== 26) begin nFails++; $display("FAIL zero_blkvalid_count actual=%0d required=26", pulses); end
    nChecks++; if (lvZdSeen !== 0) begin nFails++; $display("FAIL zero_lvzd_seen actual=%0d required=0", lvZdSeen); end
    nChecks++; if (TotalCoeff !== 5'd0) begin nFails++; $display("FAIL zero_totalcoeff actual=%0d required=0", TotalCoeff); end
    tick();
    nChecks++; if (MbDone !== 1'b1 || Busy !== 1'b1) begin nFails++; $display("FAIL zero_mbdone actual MbDone=%b Busy=%b required 1/1", MbDone, Busy); end
    tick();
    nChecks++; if (MbDone !== 1'b0 || Busy !== 1'b0) begin nFails++; $display("FAIL zero_idle actual MbDone=%b Busy=%b required 0/0", MbDone, Busy); end
  endtask

  task automatic test_block0();
    nC_In = 5'd0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    CtTotalCoeff = 5'd3;
    CtDone = 1'b1;
    tick();
    CtDone = 1'b0;
    CtTotalCoeff = 5'd0;
    nChecks++; if ({CtEn, LvEn, ZdEn} !== 3'b010 || TotalCoeff !== 5'd3) begin nFails++; $display("FAIL blk0_level actual en=%b tc=%0d required en=010 tc=3", {CtEn, LvEn, ZdEn}, TotalCoeff); end
    Start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    Start = 1'b0;
    LvDone = 1'b1; LvNumShift = 5'd9; LvShiftEn = 1'b1; CtShiftEn = 1'b1; CtNumShift = 5'd4;
    #1;
    nChecks++; if (NumShift !== 5'd9 || ShiftEn !== 1'b1 || LvEn !== 1'b1) begin nFails++; $display("FAIL level_shift actual=%0d/%b/%b required=9/1/1", NumShift, ShiftEn, LvEn); end
    tick();
    LvDone = 1'b0;
    nChecks++; if ({CtEn, LvEn, ZdEn} !== 3'b001 || NumShift !== 5'd0 || ShiftEn !== 1'b0) begin nFails++; $display("FAIL blk0_zero actual en=%b shift=%0d/%b required en=001 shift=0/0", {CtEn, LvEn, ZdEn}, NumShift, ShiftEn); end
    tick();
    tick();
    ZdDone = 1'b1;
    tick();
    ZdDone = 1'b0;
    nChecks++; if ({CtEn, LvEn, ZdEn} !== 3'b000 || BlkValid !== 1'b1 || BlkIdx !== 5'd0) begin nFails++; $display("FAIL blk0_end actual en=%b BlkValid=%b BlkIdx=%0d required 000/1/0", {CtEn, LvEn, ZdEn}, BlkValid, BlkIdx); end
    nChecks++; if (NumShift !== 5'd0 || ShiftEn !== 1'b0 || TotalCoeff !== 5'd3) begin nFails++; $display("FAIL blkend_shift actual=%0d/%b tc=%0d required=0/0 tc=3", NumShift, ShiftEn, TotalCoeff); end
    tick();
    nChecks++; if (CtEn !== 1'b1 || BlkIdx !== 5'd1 || TotalCoeff !== 5'd0 || NumShift !== 5'd4 || ShiftEn !== 1'b1) begin nFails++; $display("FAIL blk1_token actual CtEn=%b BlkIdx=%0d tc=%0d shift=%0d/%b required 1/1/0/4/1", CtEn, BlkIdx, TotalCoeff, NumShift, ShiftEn); end
    LvNumShift = 5'd0; LvShiftEn = 1'b0; CtShiftEn = 1'b0; CtNumShift = 5'd0;
    ZdDone = 1'b1;
    Start = 1'b1;
    tick();
    ZdDone = 1'b0;
    Start = 1'b0;
    nChecks++; if ({CtEn, LvEn, ZdEn} !== 3'b100 || BlkIdx !== 5'd1 || BlkValid !== 1'b0) begin nFails++; $display("FAIL spurious actual en=%b BlkIdx=%0d BlkValid=%b required 100/1/0", {CtEn, LvEn, ZdEn}, BlkIdx, BlkValid); end
    CtTotalCoeff = 5'd2;
    CtDone = 1'b1;
    tick();
    CtDone = 1'b0;
    LvDone = 1'b1;
    tick();
    LvDone = 1'b0;
    nChecks++; if (ZdEn !== 1'b1) begin nFails++; $display("FAIL blk1_zero actual=%b required=1", ZdEn); end
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    nChecks++; if ({CtEn, LvEn, ZdEn, BlkValid, MbDone, Busy, ShiftEn} !== 7'd0 || BlkIdx !== 5'd0 || TotalCoeff !== 5'd0) begin nFails++; $display("FAIL midreset actual flags=%b BlkIdx=%0d tc=%0d required 0000000/0/0", {CtEn, LvEn, ZdEn, BlkValid, MbDone, Busy, ShiftEn}, BlkIdx, TotalCoeff); end
    begin
      int mbSeen = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (MbDone !== 1'b0 || Busy !== 1'b0) mbSeen++;
      end
      nChecks++; if (mbSeen !== 0) begin nFails++; $display("FAIL midreset_after actual=%0d required=0", mbSeen); end
    end
  endtask

`ifdef CAVLC_WATCHDOG_EN
  task automatic test_watchdog();
    int early = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 63; i++) begin
      if (Error !== 1'b0) early++;
      tick();
    end
    nChecks++; if (early !== 0) begin nFails++; $display("FAIL wdog_early actual=%0d required=0", early); end
    nChecks++; if (Error !== 1'b1 || CtEn !== 1'b1) begin nFails++; $display("FAIL wdog_fire actual Error=%b CtEn=%b required 1/1", Error, CtEn); end
    tick();
    nChecks++; if ({Error, CtEn, Busy, MbDone} !== 4'b0000) begin nFails++; $display("FAIL wdog_after actual=%b required=0000", {Error, CtEn, Busy, MbDone}); end
  endtask
`endif

  initial begin
    test_reset();
    test_all_zero();
    test_block0();
`ifdef CAVLC_WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
